// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential imem requests, DEPTH-entry prefetch queue, redirect flush/drain.
// Optional JAL predecode redirect enabled by defining FETCH_JAL_PREDICT_EN.
module fetch_queue #(
    parameter int PC_W    = 9,
    parameter int INS_W   = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [PC_W-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [INS_W-1:0]              imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [PC_W-1:0]               id_pc,
    output logic [INS_W-1:0]              id_instr,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t            state, state_next;
    logic [PC_W-1:0]   fetch_pc, rsp_pc, redirect_target;
    logic [PC_W-1:0]   q_pc    [DEPTH];
    logic [INS_W-1:0]  q_instr [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [OCC_W-1:0]  count, outstanding, out_after, drop_cnt, drop_next;
    logic              rsp_fire, pop, push, issue, room, any_redirect;

    // Responses are only honoured while something is actually in flight.
    assign rsp_fire  = imem_rsp_valid && (outstanding != '0);
    assign id_valid  = (count != '0);
    assign pop       = id_valid && id_ready;
    assign id_pc     = id_valid ? q_pc[head] : '0;
    assign id_instr  = id_valid ? q_instr[head] : '0;
    assign occupancy = count;

`ifdef FETCH_JAL_PREDICT_EN
    logic               jal_hit;
    logic [20:0]        j_imm;
    logic signed [31:0] j_off;
    logic [PC_W-1:0]    jal_target;

    assign j_imm      = {imem_rsp_data[31], imem_rsp_data[19:12], imem_rsp_data[20],
                         imem_rsp_data[30:21], 1'b0};
    assign j_off      = 32'(signed'(j_imm));
    assign jal_target = rsp_pc + j_off[PC_W-1:0];
    assign jal_hit    = (state == FETCH) && rsp_fire && (imem_rsp_data[6:0] == 7'b1101111);
    assign any_redirect    = redirect_valid || jal_hit;
    assign redirect_target = redirect_valid ? redirect_pc : jal_target;
`else
    assign any_redirect    = redirect_valid;
    assign redirect_target = redirect_pc;
`endif

    // Every issued request reserves a queue slot, so responses never need backpressure.
    assign room = ({1'b0, count} + {1'b0, outstanding}) < (OCC_W + 1)'(DEPTH);
    assign imem_req_valid = !reset && (state == FETCH) && room &&
                            (outstanding < OCC_W'(MAX_OUT)) && !any_redirect;
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;
    assign push           = (state == FETCH) && rsp_fire && !redirect_valid;
    assign out_after      = outstanding + OCC_W'(issue) - OCC_W'(rsp_fire);

    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        if (any_redirect) begin
            drop_next  = out_after;
            state_next = (out_after != '0) ? DRAIN : FETCH;
        end else if (state == DRAIN && rsp_fire) begin
            drop_next = drop_cnt - OCC_W'(1);
            if (drop_cnt == OCC_W'(1)) begin
                state_next = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            drop_cnt    <= '0;
            outstanding <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_next;
            outstanding <= out_after;
            if (any_redirect) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
            end else begin
                if (issue) fetch_pc <= fetch_pc + PC_W'(4);
                if (push)  rsp_pc   <= rsp_pc + PC_W'(4);
            end
        end
    end

    // A predicted JAL keeps older entries and itself; only an external redirect clears the queue.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) head <= head + PTR_W'(1);
            if (push) begin
                q_pc[tail]    <= rsp_pc;
                q_instr[tail] <= imem_rsp_data;
                tail          <= tail + PTR_W'(1);
            end
            count <= count + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a fixed-latency, in-order memory model.
// Define FETCH_JAL_PREDICT_EN for both files to include the JAL predecode scenario.
module tb_fetch_queue;

    localparam int PC_W    = 9;
    localparam int INS_W   = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req_valid, imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INS_W-1:0]  imem_rsp_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              id_valid, id_ready;
    logic [PC_W-1:0]   id_pc;
    logic [INS_W-1:0]  id_instr;
    logic [OCC_W-1:0]  occupancy;

    always #5 clk = ~clk;

    fetch_queue #(
        .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC('0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .occupancy(occupancy)
    );

    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
    } memReq_t;

    memReq_t         pending[$];
    logic [PC_W-1:0] popQ[$];
    int  cyc, latency, reqCount, maxOcc, firstCyc;
    bit  memReady, jalMode;
    int  checkCount = 0;
    int  errorCount = 0;

    logic             sReqValid, sIdValid;
    logic [PC_W-1:0]  sReqAddr, sIdPc;
    logic [INS_W-1:0] sIdInstr;
    logic [OCC_W-1:0] sOcc;

    function automatic logic [INS_W-1:0] memWord(input logic [PC_W-1:0] a);
        if (jalMode && a == PC_W'(8)) return 32'h0100_006F;
        return 32'hA500_0000 | INS_W'(a);
    endfunction

    function automatic logic [31:0] popAt(input int i);
        if (i < popQ.size()) return 32'(popQ[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive memory response, sample outputs mid-cycle, then advance to the next negedge.
    task automatic applyStimulus();
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        imem_req_ready = memReady;
        #1;
        sReqValid = imem_req_valid;
        sReqAddr  = imem_req_addr;
        sIdValid  = id_valid;
        sIdPc     = id_pc;
        sIdInstr  = id_instr;
        sOcc      = occupancy;
        if (imem_rsp_valid) void'(pending.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            pending.push_back('{addr: imem_req_addr, due: cyc + latency});
            reqCount++;
        end
        if (id_valid && id_ready) popQ.push_back(id_pc);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        pending.delete();
        applyStimulus();
        applyStimulus();
        checkOutput("reset req_valid", 32'(sReqValid), 0);
        checkOutput("reset req_addr", 32'(sReqAddr), 0);
        checkOutput("reset id_valid", 32'(sIdValid), 0);
        checkOutput("reset id_pc", 32'(sIdPc), 0);
        checkOutput("reset id_instr", sIdInstr, 0);
        checkOutput("reset occupancy", 32'(sOcc), 0);
        reset = 1'b0;
        pending.delete();
        popQ.delete();
        reqCount = 0;
        cyc = 1;
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        memReady = 1'b1; jalMode = 1'b0; latency = 1; cyc = 0; reqCount = 0;
        @(negedge clk);

        // Streaming with single-cycle memory
        latency = 1; memReady = 1'b1; id_ready = 1'b1;
        applyReset();
        maxOcc = 0;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus();
            if (c == 1) begin
                checkOutput("t1 first req valid", 32'(sReqValid), 1);
                checkOutput("t1 first req addr", 32'(sReqAddr), 0);
            end
            if (c == 2) checkOutput("t1 id_valid c2", 32'(sIdValid), 0);
            if (c >= 3 && c <= 6) begin
                checkOutput($sformatf("t1 id_pc c%0d", c), 32'(sIdPc), 32'((c - 3) * 4));
                checkOutput($sformatf("t1 id_instr c%0d", c), sIdInstr, 32'hA500_0000 | 32'((c - 3) * 4));
            end
            if (int'(sOcc) > maxOcc) maxOcc = int'(sOcc);
        end
        checkOutput("t1 max occupancy", 32'(maxOcc), 1);

        // Decode stall fills the queue, then drains in order
        latency = 1; id_ready = 1'b0;
        applyReset();
        for (int c = 1; c <= 10; c++) applyStimulus();
        checkOutput("t2 request count", 32'(reqCount), 4);
        checkOutput("t2 occupancy full", 32'(sOcc), 4);
        checkOutput("t2 req_valid full", 32'(sReqValid), 0);
        id_ready = 1'b1;
        for (int c = 0; c < 4; c++) applyStimulus();
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t2 pop %0d", i), popAt(i), 32'(i * 4));

        // Redirect while two requests are in flight
        latency = 3; id_ready = 1'b1;
        applyReset();
        applyStimulus();
        applyStimulus();
        redirect_valid = 1'b1; redirect_pc = PC_W'(9'h040);
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("t3 no req in redirect cycle", 32'(sReqValid), 0);
        applyStimulus();
        checkOutput("t3 drain c4 req_valid", 32'(sReqValid), 0);
        applyStimulus();
        checkOutput("t3 drain c5 req_valid", 32'(sReqValid), 0);
        applyStimulus();
        checkOutput("t3 c6 req_valid", 32'(sReqValid), 1);
        checkOutput("t3 c6 req_addr", 32'(sReqAddr), 32'h40);
        firstCyc = -1;
        for (int c = 7; c <= 16 && firstCyc < 0; c++) begin
            applyStimulus();
            if (sIdValid) firstCyc = c;
        end
        checkOutput("t3 first id cycle", 32'(firstCyc), 10);
        checkOutput("t3 first id_pc", popAt(0), 32'h40);

        // Redirect coinciding with a response and a pop
        latency = 3; id_ready = 1'b0;
        applyReset();
        for (int c = 1; c <= 7; c++) applyStimulus();
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = PC_W'(9'h080);
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("t4 pop in redirect valid", 32'(sIdValid), 1);
        checkOutput("t4 pop in redirect pc", 32'(sIdPc), 0);
        applyStimulus();
        checkOutput("t4 queue empty id_valid", 32'(sIdValid), 0);
        checkOutput("t4 queue empty occupancy", 32'(sOcc), 0);
        checkOutput("t4 one stale drained req_valid", 32'(sReqValid), 0);
        applyStimulus();
        checkOutput("t4 restart req_valid", 32'(sReqValid), 1);
        checkOutput("t4 restart req_addr", 32'(sReqAddr), 32'h80);
        checkOutput("t4 pop count", 32'(popQ.size()), 1);

        // Memory not ready: address held, no duplicate request
        latency = 1; id_ready = 1'b1; memReady = 1'b0;
        applyReset();
        for (int c = 1; c <= 5; c++) begin
            applyStimulus();
            checkOutput($sformatf("t5 hold valid c%0d", c), 32'(sReqValid), 1);
            checkOutput($sformatf("t5 hold addr c%0d", c), 32'(sReqAddr), 0);
        end
        checkOutput("t5 no accepted request", 32'(reqCount), 0);
        memReady = 1'b1;
        for (int c = 0; c < 6; c++) applyStimulus();
        checkOutput("t5 pop 0", popAt(0), 0);
        checkOutput("t5 pop 1", popAt(1), 4);

`ifdef FETCH_JAL_PREDICT_EN
        // JAL predecode: 0x08 jumps +16, younger fetches dropped
        latency = 2; id_ready = 1'b0; jalMode = 1'b1;
        applyReset();
        for (int c = 1; c <= 12; c++) applyStimulus();
        checkOutput("t6 occupancy", 32'(sOcc), 4);
        id_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            if (c == 2) checkOutput("t6 jal instr", sIdInstr, 32'h0100_006F);
        end
        checkOutput("t6 pop 0", popAt(0), 32'h00);
        checkOutput("t6 pop 1", popAt(1), 32'h04);
        checkOutput("t6 pop 2", popAt(2), 32'h08);
        checkOutput("t6 pop 3", popAt(3), 32'h18);
        jalMode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
